// File: rtl/rsv_pkg.sv
// Shared types and helpers for the reservation station.
// The struct types describe the default configuration; the station re-declares them at its own widths.
package rsv_pkg;

  localparam int RSV_DEPTH     = 4;
  localparam int RSV_DATA_W    = 32;
  localparam int RSV_TAG_W     = 5;
  localparam int RSV_OPC_W     = 8;
  localparam int RSV_NUM_WB    = 2;
  localparam int RSV_MAX_DEPTH = 64;

  typedef struct packed {
    logic                  rdy;
    logic [RSV_TAG_W-1:0]  tag;
    logic [RSV_DATA_W-1:0] val;
  } rsv_src_t;

  typedef struct packed {
    logic                  valid;
    logic [RSV_OPC_W-1:0]  opc;
    logic [RSV_TAG_W-1:0]  dst_tag;
    rsv_src_t              s1;
    rsv_src_t              s2;
  } rsv_entry_t;

  // True when a valid broadcast carries the tag a source is waiting on.
  function automatic logic tag_hit(input logic wb_vld, input logic [31:0] src_tag,
                                   input logic [31:0] wb_tag);
    return wb_vld && (src_tag == wb_tag);
  endfunction

  function automatic logic [RSV_MAX_DEPTH-1:0] lowest_one(input logic [RSV_MAX_DEPTH-1:0] v);
    return v & (~v + 64'd1);
  endfunction

  function automatic int onehot_to_idx(input logic [RSV_MAX_DEPTH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < RSV_MAX_DEPTH; i++)
      if (oh[i]) idx = idx | i;
    return idx;
  endfunction

endpackage

// File: rtl/rsv_age_matrix.sv
// Allocation-order age matrix: row i holds the entries allocated before entry i.
// Produces the oldest entry among those flagged ready.
module rsv_age_matrix
  import rsv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest_oh
);

  logic [DEPTH-1:0] older_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every row updates from pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || clear)
        older_q[i] <= '0;
      else if (alloc_oh[i])
        older_q[i] <= valid & ~free_oh;
      else
        older_q[i] <= older_q[i] & ~free_oh;
    end
  end

  // An entry wins when no entry it considers older is also ready.
  always_comb begin
    oldest_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      oldest_oh[i] = ready[i] && !(|(older_q[i] & ready));
  end

endmodule

// File: rtl/rsv_station_param.sv
// Parametrised reservation station: captures operands from NUM_WB broadcast buses
// and issues the oldest instruction whose operands are all present.
module rsv_station_param
  import rsv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OPC_W  = 8,
  parameter int NUM_WB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPC_W-1:0]           in_opc,
  input  logic [TAG_W-1:0]           in_dst_tag,
  input  logic                       in_s1_rdy,
  input  logic                       in_s2_rdy,
  input  logic [TAG_W-1:0]           in_s1_tag,
  input  logic [TAG_W-1:0]           in_s2_tag,
  input  logic [DATA_W-1:0]          in_s1_val,
  input  logic [DATA_W-1:0]          in_s2_val,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_val,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [OPC_W-1:0]           ex_opc,
  output logic [TAG_W-1:0]           ex_dst_tag,
  output logic [DATA_W-1:0]          ex_s1,
  output logic [DATA_W-1:0]          ex_s2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } src_t;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [TAG_W-1:0] dst_tag;
    src_t             s1;
    src_t             s2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           woken [DEPTH];
  entry_t           new_ent;
  logic [DEPTH-1:0] valid_q;
  logic [OCC_W-1:0] occ_q;
  logic [DEPTH-1:0] ready_vec, free_oh, alloc_oh, sel_oh, fire_oh;
  logic [IDX_W-1:0] sel_idx;
  logic             alloc, fire;

  // A waiting source takes the value of the lowest-numbered matching broadcast.
  function automatic src_t wake(input src_t s);
    src_t              r;
    logic [NUM_WB-1:0] hit;
    int                ch;
    r   = s;
    hit = '0;
    for (int c = 0; c < NUM_WB; c++)
      hit[c] = tag_hit(wb_valid[c], 32'(s.tag), 32'(wb_tag[c*TAG_W +: TAG_W]));
    if (!s.rdy && (|hit)) begin
      ch    = onehot_to_idx(lowest_one(64'(hit)));
      r.rdy = 1'b1;
      r.val = wb_val[ch*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  always_comb begin
    in_ready = (occ_q < OCC_W'(DEPTH));
    free_oh  = DEPTH'(lowest_one(64'(~valid_q)));
    alloc    = in_valid && in_ready;
    alloc_oh = alloc ? free_oh : '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] && ent_q[i].s1.rdy && ent_q[i].s2.rdy;
      woken[i]     = ent_q[i];
      woken[i].s1  = wake(ent_q[i].s1);
      woken[i].s2  = wake(ent_q[i].s2);
    end
    new_ent.opc     = in_opc;
    new_ent.dst_tag = in_dst_tag;
    new_ent.s1      = wake('{rdy: in_s1_rdy, tag: in_s1_tag, val: in_s1_val});
    new_ent.s2      = wake('{rdy: in_s2_rdy, tag: in_s2_tag, val: in_s2_val});
  end

  rsv_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .valid     (valid_q),
    .alloc_oh  (alloc_oh),
    .free_oh   (fire_oh),
    .ready     (ready_vec),
    .oldest_oh (sel_oh)
  );

  always_comb begin
    ex_valid   = |sel_oh;
    sel_idx    = IDX_W'(onehot_to_idx(64'(sel_oh)));
    fire       = ex_valid && ex_ready;
    fire_oh    = fire ? sel_oh : '0;
    ex_opc     = ex_valid ? ent_q[sel_idx].opc     : '0;
    ex_dst_tag = ex_valid ? ent_q[sel_idx].dst_tag : '0;
    ex_s1      = ex_valid ? ent_q[sel_idx].s1.val  : '0;
    ex_s2      = ex_valid ? ent_q[sel_idx].s2.val  : '0;
    occupancy  = occ_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= (valid_q & ~fire_oh) | alloc_oh;
      occ_q   <= occ_q + OCC_W'(alloc) - OCC_W'(fire);
    end
  end

  // NOTE: payload storage carries no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      ent_q[i] <= alloc_oh[i] ? new_ent : woken[i];
  end

endmodule

// File: tb/tb_rsv_station_param.sv
// Self-checking bench: directed scenarios plus random traffic against an in-order queue model.
module tb_rsv_station_param;
  import rsv_pkg::*;

  localparam int DEPTH = 4, DATA_W = 32, TAG_W = 5, OPC_W = 8, NUM_WB = 2;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic                     clk = 1'b0;
  logic                     rst, flush, in_valid, in_ready;
  logic [OPC_W-1:0]         in_opc;
  logic [TAG_W-1:0]         in_dst_tag, in_s1_tag, in_s2_tag;
  logic                     in_s1_rdy, in_s2_rdy;
  logic [DATA_W-1:0]        in_s1_val, in_s2_val;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_val;
  logic                     ex_valid, ex_ready;
  logic [OPC_W-1:0]         ex_opc;
  logic [TAG_W-1:0]         ex_dst_tag;
  logic [DATA_W-1:0]        ex_s1, ex_s2;
  logic [OCC_W-1:0]         occupancy;

  always #5 clk = ~clk;

  rsv_station_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                      .OPC_W(OPC_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_dst_tag(in_dst_tag),
    .in_s1_rdy(in_s1_rdy), .in_s2_rdy(in_s2_rdy), .in_s1_tag(in_s1_tag), .in_s2_tag(in_s2_tag),
    .in_s1_val(in_s1_val), .in_s2_val(in_s2_val),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opc(ex_opc), .ex_dst_tag(ex_dst_tag),
    .ex_s1(ex_s1), .ex_s2(ex_s2), .occupancy(occupancy)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  rsv_entry_t mq[$];      // live instructions, oldest first
  bit         m_cleared;  // state was just wiped by reset or flush

  // Two channels carrying one tag is legal but worth flagging; the design takes channel 0.
  always @(negedge clk)
    if (rst === 1'b0)
      assert (!(wb_valid == 2'b11 && wb_tag[4:0] == wb_tag[9:5]))
        else $warning("both broadcast channels carry tag %0d", wb_tag[4:0]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel();
    foreach (mq[i]) if (mq[i].s1.rdy && mq[i].s2.rdy) return i;
    return -1;
  endfunction

  function automatic rsv_src_t m_wake(input rsv_src_t s);
    rsv_src_t r;
    r = s;
    if (r.rdy) return r;
    for (int c = 0; c < NUM_WB; c++)
      if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == r.tag) begin
        r.rdy = 1'b1;
        r.val = wb_val[c*DATA_W +: DATA_W];
        return r;
      end
    return r;
  endfunction

  task automatic check_outputs();
    int s;
    s = m_sel();
    check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("ex_valid",  64'(ex_valid),  64'(s >= 0));
    if (s >= 0) begin
      check("ex_opc",     64'(ex_opc),     64'(mq[s].opc));
      check("ex_dst_tag", 64'(ex_dst_tag), 64'(mq[s].dst_tag));
      check("ex_s1",      64'(ex_s1),      64'(mq[s].s1.val));
      check("ex_s2",      64'(ex_s2),      64'(mq[s].s2.val));
    end else if (m_cleared) begin
      check("clr_opc", 64'(ex_opc), 64'd0);
      check("clr_dst", 64'(ex_dst_tag), 64'd0);
      check("clr_s1",  64'(ex_s1), 64'd0);
      check("clr_s2",  64'(ex_s2), 64'd0);
    end
    m_cleared = 1'b0;
  endtask

  task automatic model_edge();
    int         s;
    bit         fire, alloc;
    rsv_entry_t e;
    if (rst || flush) begin
      mq.delete();
      m_cleared = 1'b1;
    end else begin
      s     = m_sel();
      fire  = (s >= 0) && ex_ready;
      alloc = in_valid && (mq.size() < DEPTH);
      foreach (mq[i]) begin
        mq[i].s1 = m_wake(mq[i].s1);
        mq[i].s2 = m_wake(mq[i].s2);
      end
      if (fire) mq.delete(s);
      if (alloc) begin
        e.valid   = 1'b1;
        e.opc     = in_opc;
        e.dst_tag = in_dst_tag;
        e.s1      = m_wake('{rdy: in_s1_rdy, tag: in_s1_tag, val: in_s1_val});
        e.s2      = m_wake('{rdy: in_s2_rdy, tag: in_s2_tag, val: in_s2_val});
        mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] opc, input logic [4:0] dst,
                       input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [4:0] t2, input logic [31:0] v2);
    in_valid = 1'b1; in_opc = opc; in_dst_tag = dst;
    in_s1_rdy = r1; in_s1_tag = t1; in_s1_val = v1;
    in_s2_rdy = r2; in_s2_tag = t2; in_s2_val = v2;
  endtask

  task automatic bcast(input int ch, input logic [4:0] tag, input logic [31:0] val);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W]   = tag;
    wb_val[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic quiet();
    in_valid = 1'b0;
    wb_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    in_valid = 1'b0; in_opc = '0; in_dst_tag = '0;
    in_s1_rdy = 1'b0; in_s2_rdy = 1'b0; in_s1_tag = '0; in_s2_tag = '0;
    in_s1_val = '0; in_s2_val = '0;
    wb_valid = '0; wb_tag = '0; wb_val = '0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); m_cleared = 1'b1;
    rst = 1'b0;

    // Reset state, then a fully-ready alloc issues one cycle later
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    ex_ready = 1'b1;
    offer(8'h11, 5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
    step();
    quiet();
    check("t1_ex_valid", 64'(ex_valid), 64'd1);
    check("t1_ex_s1", 64'(ex_s1), 64'd5);
    check("t1_ex_s2", 64'(ex_s2), 64'd7);
    check("t1_dst", 64'(ex_dst_tag), 64'd3);
    step();
    check("t1_occ_after", 64'(occupancy), 64'd0);

    // Younger ready entry overtakes a waiting one; broadcast on channel 1 completes it
    offer(8'h21, 5'd1, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'd2);
    step();
    offer(8'h22, 5'd2, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4);
    step();
    quiet();
    check("t2_b_first", 64'(ex_dst_tag), 64'd2);
    bcast(1, 5'd9, 32'hAB);
    step();
    quiet();
    check("t2_a_dst", 64'(ex_dst_tag), 64'd1);
    check("t2_a_s1", 64'(ex_s1), 64'hAB);
    step();

    // Alloc bypass: source matched by a same-cycle broadcast is stored ready
    offer(8'h31, 5'd5, 1'b1, 5'd0, 32'd1, 1'b0, 5'd4, 32'd0);
    bcast(0, 5'd4, 32'h55);
    step();
    quiet();
    check("t3_ex_valid", 64'(ex_valid), 64'd1);
    check("t3_ex_s2", 64'(ex_s2), 64'h55);
    step();

    // Fill with waiting entries, wake them all under stall, oldest is held until accepted
    ex_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offer(8'(8'h40 + i), 5'(8 + i), 1'b0, 5'(10 + i), 32'd0, 1'b1, 5'd0, 32'(100 + i));
      step();
    end
    offer(8'h4F, 5'd15, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
    check("t4_full_in_ready", 64'(in_ready), 64'd0);
    check("t4_full_occ", 64'(occupancy), 64'd4);
    step();
    quiet();
    bcast(0, 5'd10, 32'hA0); bcast(1, 5'd11, 32'hA1);
    step();
    quiet();
    bcast(0, 5'd12, 32'hA2); bcast(1, 5'd13, 32'hA3);
    check("t4_oldest", 64'(ex_dst_tag), 64'd8);
    step();
    quiet();
    check("t4_hold_valid", 64'(ex_valid), 64'd1);
    check("t4_hold_dst", 64'(ex_dst_tag), 64'd8);
    check("t4_hold_s1", 64'(ex_s1), 64'hA0);
    step();
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    check("t4_slot_freed", 64'(in_ready), 64'd1);
    check("t4_next_dst", 64'(ex_dst_tag), 64'd9);
    ex_ready = 1'b1;
    repeat (3) step();

    // Flush beats a simultaneous alloc
    ex_ready = 1'b0;
    offer(8'h51, 5'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1); step();
    offer(8'h52, 5'd2, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd2); step();
    offer(8'h53, 5'd3, 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'd3); step();
    flush = 1'b1;
    offer(8'h54, 5'd7, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
    step();
    flush = 1'b0;
    quiet();
    check("t5_occ", 64'(occupancy), 64'd0);
    check("t5_ex_valid", 64'(ex_valid), 64'd0);
    step();

    // Random traffic with an occasional flush and one mid-run reset
    for (int cyc = 0; cyc < 600; cyc++) begin
      int t0, t1;
      rst        = (cyc == 300);
      flush      = ($urandom_range(49) == 0);
      in_valid   = $urandom_range(1) == 1;
      in_opc     = 8'($urandom);
      in_dst_tag = 5'($urandom);
      in_s1_rdy  = $urandom_range(2) != 0;
      in_s2_rdy  = $urandom_range(2) != 0;
      in_s1_tag  = 5'($urandom_range(7));
      in_s2_tag  = 5'($urandom_range(7));
      in_s1_val  = $urandom;
      in_s2_val  = $urandom;
      t0 = $urandom_range(7);
      t1 = (t0 + 1 + $urandom_range(6)) % 8;
      wb_valid = 2'($urandom);
      wb_tag   = {5'(t1), 5'(t0)};
      wb_val   = {$urandom, $urandom};
      ex_ready = $urandom_range(3) != 0;
      step();
      if (cyc == 300) begin
        check("rnd_rst_valid", 64'(ex_valid), 64'd0);
        check("rnd_rst_occ", 64'(occupancy), 64'd0);
        check("rnd_rst_in_ready", 64'(in_ready), 64'd1);
        check("rnd_rst_opc", 64'(ex_opc), 64'd0);
      end
    end
    rst = 1'b0; flush = 1'b0;
    quiet();
    ex_ready = 1'b1;
    repeat (DEPTH + 1) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
